// File: rtl/nucleo_pipeline.sv
// nucleo_pipeline: 4-stage (fetch, decode/RF read, execute/memory, writeback) 16-bit-instruction core
// with W->E forwarding, RF write-through, branch flush, freeze input and halt detection.
module nucleo_pipeline #(
   parameter int          DATA_W  = 16,
   parameter int          PC_W    = 16,
   parameter int          DADDR_W = 16,
   parameter int unsigned RST_PC  = 0,
   parameter int          CNT_W   = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               stall,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [15:0]        imem_data,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic               dmem_we,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   output logic               halted,
   output logic [CNT_W-1:0]   retired
);

   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SLT  = 4'h6;
   localparam logic [3:0] OP_LDI  = 4'h7;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_BNZ  = 4'hA;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [PC_W-1:0]   RST_PC_V = PC_W'(RST_PC);
   localparam logic [PC_W-1:0]   PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic                fetch_en_r, f_valid_r, e_valid_r, w_valid_r, w_halt_r, w_wr_r, w_ld_r, halted_r;
   logic [PC_W-1:0]     pc_r, f_pc_r, e_pc_r, target_s;
   logic [15:0]         e_instr_r;
   logic [3:0]          e_op_s, w_rd_r;
   logic [DATA_W-1:0]   e_a_r, e_b_r, e_c_r, w_res_r, w_res_s;
   logic [DATA_W-1:0]   d_a_s, d_b_s, d_c_s, opa_s, opb_s, opc_s, imm_s, alu_s;
   logic                wr_s, ld_s, take_s, halt_s, flush_s;
   logic [CNT_W-1:0]    retired_r;
   logic [DATA_W-1:0]   rf_r [16];

   // imem_data is the fetched word itself, so D decodes it directly; a same-cycle W write wins.
   assign w_res_s = w_ld_r ? dmem_rdata : w_res_r;
   assign d_a_s   = (w_wr_r && (w_rd_r == imem_data[7:4]))  ? w_res_s : rf_r[imem_data[7:4]];
   assign d_b_s   = (w_wr_r && (w_rd_r == imem_data[3:0]))  ? w_res_s : rf_r[imem_data[3:0]];
   assign d_c_s   = (w_wr_r && (w_rd_r == imem_data[11:8])) ? w_res_s : rf_r[imem_data[11:8]];

   assign e_op_s   = e_instr_r[15:12];
   assign opa_s    = (w_wr_r && (w_rd_r == e_instr_r[7:4]))  ? w_res_s : e_a_r;
   assign opb_s    = (w_wr_r && (w_rd_r == e_instr_r[3:0]))  ? w_res_s : e_b_r;
   assign opc_s    = (w_wr_r && (w_rd_r == e_instr_r[11:8])) ? w_res_s : e_c_r;
   assign imm_s    = DATA_W'($signed(e_instr_r[7:0]));
   assign target_s = e_pc_r + PC_W'($signed(e_instr_r[7:0]));
   assign take_s   = e_valid_r && (e_op_s == OP_BNZ) && (opc_s != '0);
   assign halt_s   = e_valid_r && (e_op_s == OP_HALT);
   assign flush_s  = take_s || halt_s;

   // Execute-stage ALU and register-write decode
   always_comb begin
      alu_s = '0;
      wr_s  = 1'b0;
      ld_s  = 1'b0;
      case (e_op_s)
         OP_ADD:  begin alu_s = opa_s + opb_s; wr_s = 1'b1; end
         OP_SUB:  begin alu_s = opa_s - opb_s; wr_s = 1'b1; end
         OP_AND:  begin alu_s = opa_s & opb_s; wr_s = 1'b1; end
         OP_OR:   begin alu_s = opa_s | opb_s; wr_s = 1'b1; end
         OP_XOR:  begin alu_s = opa_s ^ opb_s; wr_s = 1'b1; end
         OP_SLT:  begin alu_s = ($signed(opa_s) < $signed(opb_s)) ? DATA_ONE : '0; wr_s = 1'b1; end
         OP_LDI:  begin alu_s = imm_s; wr_s = 1'b1; end
         OP_LD:   begin wr_s = 1'b1; ld_s = 1'b1; end
         default: begin alu_s = '0; wr_s = 1'b0; ld_s = 1'b0; end
      endcase
   end

   assign dmem_we    = e_valid_r && (e_op_s == OP_ST) && !stall;
   assign dmem_wdata = e_valid_r ? opb_s : '0;

   generate
      if (DADDR_W <= DATA_W) begin : g_addr_trunc
         assign dmem_addr = e_valid_r ? opa_s[DADDR_W-1:0] : '0;
      end else begin : g_addr_ext
         assign dmem_addr = e_valid_r ? {{(DADDR_W-DATA_W){1'b0}}, opa_s} : '0;
      end
   endgenerate

   // Fetch: PC, in-flight fetch tracking; fetch_en_r idles the first edge after reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_en_r <= 1'b0;
         pc_r       <= RST_PC_V;
         f_valid_r  <= 1'b0;
         f_pc_r     <= RST_PC_V;
      end else if (!stall) begin
         fetch_en_r <= 1'b1;
         if (take_s) begin
            pc_r      <= target_s;
            f_valid_r <= 1'b0;
         end else if (fetch_en_r && !halted_r && !halt_s) begin
            pc_r      <= pc_r + PC_ONE;
            f_valid_r <= 1'b1;
            f_pc_r    <= pc_r;
         end else begin
            f_valid_r <= 1'b0;
         end
      end
   end

   // D -> E pipeline register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         e_valid_r <= 1'b0;
         e_instr_r <= 16'h0000;
         e_pc_r    <= RST_PC_V;
         e_a_r     <= '0;
         e_b_r     <= '0;
         e_c_r     <= '0;
      end else if (!stall) begin
         e_valid_r <= f_valid_r && !flush_s;
         e_instr_r <= imem_data;
         e_pc_r    <= f_pc_r;
         e_a_r     <= d_a_s;
         e_b_r     <= d_b_s;
         e_c_r     <= d_c_s;
      end
   end

   // E -> W pipeline register, register file, halt flag and retire counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         w_valid_r <= 1'b0;
         w_halt_r  <= 1'b0;
         w_wr_r    <= 1'b0;
         w_ld_r    <= 1'b0;
         w_rd_r    <= 4'h0;
         w_res_r   <= '0;
         halted_r  <= 1'b0;
         retired_r <= '0;
         for (int i = 0; i < 16; i++) rf_r[i] <= '0;
      end else if (!stall) begin
         w_valid_r <= e_valid_r;
         w_halt_r  <= halt_s;
         w_wr_r    <= e_valid_r && wr_s;
         w_ld_r    <= e_valid_r && ld_s;
         w_rd_r    <= e_instr_r[11:8];
         w_res_r   <= alu_s;
         if (w_wr_r) rf_r[w_rd_r] <= w_res_s;
         if (halt_s) halted_r <= 1'b1;
         if (w_valid_r && !w_halt_r) retired_r <= retired_r + CNT_ONE;
      end
   end

   assign imem_addr = pc_r;
   assign halted    = halted_r;
   assign retired   = retired_r;

endmodule
